// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM state encodings, default baud divisor).
// Imported by uart_rx and uart_tx so a TX/RX pair agrees on encodings.
package uart_pkg;

    // 100 MHz system clock / 9600 baud
    localparam int CLK_PER_BIT = 10417;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line and the receiver's byte-side outputs.
// master = receiver (drives byte/flags), slave = line driver + byte consumer.
interface uart_rx_if;
    logic       rx_serial_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    modport master (
        input  rx_serial_data,
        output rx_byte,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output parity_err
    );

    modport slave (
        output rx_serial_data,
        input  rx_byte,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: 2-flop metastability synchronizer for an async input.
// Ports: i_clk, i_rst_n (async low), i_d (async in), o_q (synced out).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], i_d};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= {2{RST_VAL}};
        else          sync_q <= sync_d;
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling; optional even parity
// when UART_RX_PARITY_EN is defined. Ports: i_clk, i_rst_n (async low),
// i_rx_serial_data (line), o_rx_byte, o_rx_valid, o_rx_busy, o_frame_err,
// o_parity_err (valid/err outputs are one-cycle registered pulses).
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_per_bit = CLK_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_serial_data,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_busy,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam int CW = (clk_per_bit > 1) ? $clog2(clk_per_bit) : 1;
    localparam logic [CW-1:0] HALF = CW'(clk_per_bit / 2);
    localparam logic [CW-1:0] LAST = CW'(clk_per_bit - 1);

    logic          rx_s;
    logic          rx_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
    logic          par_bad_q, par_bad_d;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx_serial_data),
        .o_q     (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                // falling edge of the synchronized line
                if (rx_q && !rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    // still high at mid start bit: treat as glitch
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            S_CLEANUP: begin
                // hold here while a break keeps the line low
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_q    <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_q    <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
        end
    end
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_rx_byte   = byte_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = ferr_q;
    assign o_rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at clk_per_bit=16 with a byte
// scoreboard; build with +define+UART_RX_PARITY_EN to cover the parity path.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif
    // line is driven just after edge 0 and first captured at edge 1;
    // the pulse shows after the stop sample edge
    localparam int EXP_LAT = 1 + 2 + CPB / 2 + (FLEN - 1) * CPB + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   valid_cnt = 0;
    int   ferr_cnt = 0;
    int   perr_cnt = 0;
    int   valid_cyc = 0;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;
    logic prev_p = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_if rif ();

    uart_rx #(.clk_per_bit(CPB)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rx_serial_data (rif.rx_serial_data),
        .o_rx_byte        (rif.rx_byte),
        .o_rx_valid       (rif.rx_valid),
        .o_rx_busy        (rif.rx_busy),
        .o_frame_err      (rif.frame_err),
        .o_parity_err     (rif.parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame(input logic [7:0] d,
                                          input logic stop_b,
                                          input logic flip_par);
        logic [31:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_RX_PARITY_EN
        f[9]  = (^d) ^ flip_par;
        f[10] = stop_b;
`else
        f[9] = stop_b;
        if (flip_par) f[9] = stop_b;
`endif
        return f;
    endfunction

    // call just after a rising edge; bit period is per_x100/100 cycles
    task automatic send_bits(input logic [31:0] bits, input int n,
                             input int per_x100);
        int tot;
        tot = (n * per_x100) / 100;
        for (int c = 0; c < tot; c++) begin
            rif.rx_serial_data = bits[(c * 100) / per_x100];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int target, input int budget);
        for (int i = 0; i < budget && valid_cnt < target; i++)
            @(negedge clk);
        chk("valid_count", valid_cnt, target);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rif.rx_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                chk("valid_width", {31'd0, prev_v}, 0);
                chk("valid_excl", {31'd0, rif.frame_err | rif.parity_err}, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {24'd0, rif.rx_byte}, 32'hFFFF);
                end else begin
                    chk("byte", {24'd0, rif.rx_byte},
                        {24'd0, exp_q.pop_front()});
                end
            end
            if (rif.frame_err) begin
                ferr_cnt++;
                chk("ferr_width", {31'd0, prev_f}, 0);
            end
            if (rif.parity_err) begin
                perr_cnt++;
                chk("perr_width", {31'd0, prev_p}, 0);
            end
            prev_v = rif.rx_valid;
            prev_f = rif.frame_err;
            prev_p = rif.parity_err;
        end else begin
            prev_v = 1'b0;
            prev_f = 1'b0;
            prev_p = 1'b0;
        end
    end

    initial begin
        int          t0;
        logic [31:0] f;
        logic [31:0] mask;
        mask = (32'd1 << FLEN) - 1;

        rif.rx_serial_data = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_byte", {24'd0, rif.rx_byte}, 0);
        chk("rst_valid", {31'd0, rif.rx_valid}, 0);
        chk("rst_busy", {31'd0, rif.rx_busy}, 0);
        chk("rst_ferr", {31'd0, rif.frame_err}, 0);
        chk("rst_perr", {31'd0, rif.parity_err}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // idle line
        repeat (500) @(posedge clk);
        @(negedge clk);
        chk("idle_valid", valid_cnt, 0);
        chk("idle_ferr", ferr_cnt, 0);
        chk("idle_perr", perr_cnt, 0);
        chk("idle_busy", {31'd0, rif.rx_busy}, 0);
        @(posedge clk);
        #1;

        // 0xA5 at exact baud
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send_bits(frame(8'hA5, 1'b1, 1'b0), FLEN, 1600);
        rif.rx_serial_data = 1'b1;
        wait_valid(1, 200);
        chk("a5_latency", valid_cyc - t0, EXP_LAT);
        chk("a5_byte", {24'd0, rif.rx_byte}, 32'hA5);
        chk("a5_ferr", ferr_cnt, 0);
        chk("a5_perr", perr_cnt, 0);
        repeat (20) @(posedge clk);
        #1;

        // 5-cycle low glitch
        rif.rx_serial_data = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("glitch_busy_hi", {31'd0, rif.rx_busy}, 1);
        @(posedge clk);
        #1 rif.rx_serial_data = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_lo", {31'd0, rif.rx_busy}, 0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("glitch_valid", valid_cnt, 1);
        chk("glitch_ferr", ferr_cnt, 0);
        @(posedge clk);
        #1;

        // 0x3C with stop bit low, line held low afterwards
        send_bits(frame(8'h3C, 1'b0, 1'b0), FLEN, 1600);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("ferr_count", ferr_cnt, 1);
        chk("ferr_valid", valid_cnt, 1);
        chk("ferr_byte_kept", {24'd0, rif.rx_byte}, 32'hA5);
        chk("ferr_cleanup_busy", {31'd0, rif.rx_busy}, 1);
        @(posedge clk);
        #1 rif.rx_serial_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ferr_idle_busy", {31'd0, rif.rx_busy}, 0);
        repeat (20) @(posedge clk);
        #1;

        // back-to-back 0x00, 0xFF with sender 3% slow
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        f = (frame(8'hFF, 1'b1, 1'b0) << FLEN) | (frame(8'h00, 1'b1, 1'b0) & mask);
        send_bits(f, 2 * FLEN, 1648);
        rif.rx_serial_data = 1'b1;
        wait_valid(3, 300);
        chk("b2b_ferr", ferr_cnt, 1);
        chk("b2b_byte", {24'd0, rif.rx_byte}, 32'hFF);
        repeat (20) @(posedge clk);
        #1;

        // reset during data bit 4
        f = frame(8'h55, 1'b1, 1'b0);
        send_bits(f, 5, 1600);
        rif.rx_serial_data = f[5];
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rif.rx_serial_data = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("mrst_valid", valid_cnt, 3);
        chk("mrst_ferr", ferr_cnt, 1);
        chk("mrst_busy", {31'd0, rif.rx_busy}, 0);
        chk("mrst_byte", {24'd0, rif.rx_byte}, 0);
        @(posedge clk);
        #1;
        exp_q.push_back(8'h96);
        send_bits(frame(8'h96, 1'b1, 1'b0), FLEN, 1600);
        rif.rx_serial_data = 1'b1;
        wait_valid(4, 200);
        repeat (20) @(posedge clk);
        #1;

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_bits(frame(8'h07, 1'b1, 1'b0), FLEN, 1600);
        rif.rx_serial_data = 1'b1;
        wait_valid(5, 200);
        chk("par_ok_perr", perr_cnt, 0);
        repeat (20) @(posedge clk);
        #1;
        send_bits(frame(8'h07, 1'b1, 1'b1), FLEN, 1600);
        rif.rx_serial_data = 1'b1;
        for (int i = 0; i < 200 && perr_cnt < 1; i++) @(negedge clk);
        chk("par_bad_perr", perr_cnt, 1);
        chk("par_bad_valid", valid_cnt, 5);
        chk("par_bad_byte", {24'd0, rif.rx_byte}, 32'h07);
        repeat (20) @(posedge clk);
`endif

        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that is the line-side counterpart of `uart_tx`. It samples an asynchronous 8N1 serial line, with an optional even-parity bit, and delivers each received byte as a parallel word with a one-cycle valid pulse. It sits at the chip's RX pin and feeds byte consumers such as a command parser or an RX FIFO. It uses the same `clk_per_bit` baud convention as `uart_tx`, so a TX/RX pair configured identically loops back cleanly.

## Interface
- `clk_per_bit`, 10417, system clocks per bit period (100 MHz / 9600 baud); legal range ≥ 4.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `i_rx_serial_data`  in  1  serial line, asynchronous to `i_clk`, idles high.
- `o_rx_byte`  out  8  last good byte, LSB first on the wire; holds until the next good byte.
- `o_rx_valid`  out  1  one-cycle pulse: `o_rx_byte` was just updated.
- `o_rx_busy`  out  1  high in every state except IDLE.
- `o_frame_err`  out  1  one-cycle pulse: stop bit was sampled low.
- `o_parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 when parity is compiled out).

## Operation
- The line passes through a 2-flop synchronizer (`rx_s`). Start detection uses `rx_s` high→low, compared against a third registered copy.
- Bit counter `cnt` has width $clog2(`clk_per_bit`) and counts 0..`clk_per_bit`-1. Bit index `idx` has width 3.
- **IDLE**
  - `cnt`=0, `idx`=0.
  - Falling edge on `rx_s` → START.
- **START**
  - At `cnt`==`clk_per_bit`/2 (integer division), sample `rx_s`.
  - Low → clear `cnt` → DATA.
  - High → glitch: return to IDLE with no output pulse.
- **DATA**
  - At `cnt`==`clk_per_bit`-1, sample `rx_s` into shift register bit `idx`, then clear `cnt`.
  - `idx`==7 → PARITY if compiled in, else STOP. Otherwise `idx`+1.
- **PARITY**
  - Sample at `cnt`==`clk_per_bit`-1.
  - Error flag = sampled bit XOR (XOR of the 8 data bits).
  - → STOP.
- **STOP**
  - Sample at `cnt`==`clk_per_bit`-1.
  - High and no parity error → copy shift register to `o_rx_byte`, pulse `o_rx_valid`.
  - High with parity error → pulse `o_parity_err` only; `o_rx_byte` is unchanged.
  - Low → pulse `o_frame_err`; `o_rx_byte` is unchanged.
  - Next state → CLEANUP.
- **CLEANUP**
  - Stay until `rx_s` is high. This absorbs break conditions and prevents a false start on a held-low line.
  - → IDLE.
- Out-of-range state encodings → IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; `cnt`, `idx` and the shift register 0; synchronizer flops 1 (line idle).
- Reset asserted mid-frame aborts immediately with no pulses. After release the block waits in IDLE for a fresh falling edge.
- Sampling points: mid-bit, at line falling edge + 2 (sync) + `clk_per_bit`/2 + k·`clk_per_bit` cycles, where k=1..8 for data, 9 for parity (if present), and 9 or 10 for stop.
- `o_rx_valid` / `o_frame_err` / `o_parity_err` are registered. They assert the cycle after the stop sample and last exactly 1 cycle. At most one of them pulses per frame.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. The stop sample is at mid-bit and CLEANUP exits in 1 cycle on a high line, leaving ≥ `clk_per_bit`/2 - 2 cycles of margin before the next falling edge.
- Tolerated baud mismatch: ±4 % (mid-bit sampling over 10 or 11 bits).

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: an even-parity bit follows bit 7 (11-bit frame); PARITY state and `o_parity_err` logic are present.
- Undefined: 8N1 (10-bit frame); PARITY state removed; `o_parity_err` tied 0. The port list is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP (3 bits).
  - Default `CLK_PER_BIT` = 10417.
  - `uart_tx` imports the same package for its encodings.
- Sub-module `uart_sync2`: 2-flop metastability synchronizer with parameterised reset value (1 here). It is reusable for other async inputs.
- All other logic (FSM, counter, shift register) lives in `uart_rx`.

## Test plan
Use `clk_per_bit`=16 for simulation speed.
- Reset then idle-high line for 500 cycles → all outputs remain 0, `o_rx_busy`=0.
- Drive frame for 0xA5 at exact baud → `o_rx_byte`=0xA5 and `o_rx_valid` is a single-cycle pulse at falling edge + 2 + 8 + 9·16 + 1 cycles. No error pulses.
- Low glitch of 5 cycles on an idle line → no pulses, block back in IDLE, `o_rx_busy` drops by cycle 2+8+1.
- Frame 0x3C with stop bit held low, then line high → `o_frame_err` pulses once, `o_rx_byte` keeps its previous value, block leaves CLEANUP only after the line returns high.
- Two frames 0x00 then 0xFF with zero idle between them, and sender baud off by +3 % → two `o_rx_valid` pulses with bytes 0x00 and 0xFF.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → valid. 0x07 with parity bit 0 → `o_parity_err` pulse, no `o_rx_valid`. Reset asserted at data bit 4 → no pulses, next good frame received normally.
